// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter with repeat count
// Optional build macro: SEQ_PATTERN_TX_LSB_FIRST_EN selects LSB-first bit order.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_pattern,
    input  logic [CNT_W-1:0] load_repeat,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] pat;
    logic [CNT_W-1:0] rep;
    logic [BW-1:0]    bit_cnt;
    logic             wrap;
    logic             take;
    logic             cur_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign wrap = (bit_cnt == BW'(WIDTH - 1));
    assign take = load_valid && load_ready;

`ifdef SEQ_PATTERN_TX_LSB_FIRST_EN
    assign cur_bit       = shreg[0];
    assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
`else
    assign cur_bit       = shreg[WIDTH-1];
    assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // load_valid is tested directly here rather than through take, so the
    // ready/next-state decode stays free of a combinational self-loop.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        case (state)
            IDLE: begin
                load_ready = !rst;
                if (load_valid && !rst) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (wrap && (rep == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            pat     <= '0;
            rep     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        shreg   <= load_pattern;
                        pat     <= load_pattern;
                        rep     <= load_repeat;
                        bit_cnt <= '0;
                    end
                end
                SEND: begin
                    if (wrap) begin
                        bit_cnt <= '0;
                        // Reload on the wrap edge so repetitions run back-to-back.
                        if (rep != '0) begin
                            rep   <= rep - CNT_W'(1);
                            shreg <= pat;
                        end else begin
                            shreg <= shreg_shifted;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                        shreg   <= shreg_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode flops only; no input reaches them combinationally.
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out       = out_valid && cur_bit;
    assign last      = out_valid && (rep == '0) && wrap;

endmodule
